// File: rtl/rgb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rgb_pkg
// Purpose  : LED word format shared by rgb_word_pack and the serial output stage.
// Revision : 1.0
// ============================================================================
package rgb_pkg;

    localparam int BNUM_VALID        = 31;
    localparam int BNUM_STREAM_RESET = 30;
    localparam int BNUM_G_MSB        = 23;
    localparam int BNUM_G_LSB        = 16;
    localparam int BNUM_R_MSB        = 15;
    localparam int BNUM_R_LSB        = 8;
    localparam int BNUM_B_MSB        = 7;
    localparam int BNUM_B_LSB        = 0;

    localparam int          LED_BITS          = 24;
    localparam logic [31:0] STREAM_RESET_WORD = 32'hC000_0000;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_PEND = 1'b1
    } pack_state_e;

    // GRB pixel arrives MSB-first, so the oldest bit sits in G[7].
    function automatic logic [31:0] make_data_word(input logic [23:0] grb);
        logic [31:0] w;
        w                          = '0;
        w[BNUM_VALID]              = 1'b1;
        w[BNUM_STREAM_RESET]       = 1'b0;
        w[BNUM_G_MSB:BNUM_G_LSB]   = grb[23:16];
        w[BNUM_R_MSB:BNUM_R_LSB]   = grb[15:8];
        w[BNUM_B_MSB:BNUM_B_LSB]   = grb[7:0];
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb_word_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : rgb_word_pack_if
// Purpose  : Decoder event inputs and FIFO write port of rgb_word_pack.
//            Optional macro: RGB_WORD_PACK_STATS_EN adds out_led_count.
// Revision : 1.0
// ============================================================================
interface rgb_word_pack_if;

    logic        in_strobe;
    logic        in_stream_reset;
    logic        in_sbit_value;
    logic        in_wr_fifo_full;
    logic        out_wr_fifo_en;
    logic [31:0] out_wr_fifo_data;
    logic        out_overflow;
    logic        out_frame_err;
`ifdef RGB_WORD_PACK_STATS_EN
    logic [15:0] out_led_count;
`endif

    modport master (
        output in_strobe, in_stream_reset, in_sbit_value, in_wr_fifo_full,
        input  out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_frame_err
`ifdef RGB_WORD_PACK_STATS_EN
        , input out_led_count
`endif
    );

    modport slave (
        input  in_strobe, in_stream_reset, in_sbit_value, in_wr_fifo_full,
        output out_wr_fifo_en, out_wr_fifo_data, out_overflow, out_frame_err
`ifdef RGB_WORD_PACK_STATS_EN
        , output out_led_count
`endif
    );

endinterface
`default_nettype wire

// File: rtl/rgb_strobe_rise.sv
`default_nettype none
// ============================================================================
// Module   : rgb_strobe_rise
// Purpose  : One event per decoder strobe, on the first cycle it is seen high.
// Revision : 1.0
// ============================================================================
module rgb_strobe_rise (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_strobe,
    output logic      o_event
);

    logic strobe_d_q;
    logic strobe_d_d;

    always_comb begin
        strobe_d_d = i_strobe;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_d_q <= 1'b0;
        end else begin
            strobe_d_q <= strobe_d_d;
        end
    end

    assign o_event = i_strobe & ~strobe_d_q;

endmodule
`default_nettype wire

// File: rtl/rgb_word_pack.sv
`default_nettype none
// ============================================================================
// Module   : rgb_word_pack
// Purpose  : Packs decoded WS2812b bit events into 32-bit FIFO words.
//            Optional macro: RGB_WORD_PACK_STATS_EN (out_led_count).
// Revision : 1.0
// ============================================================================
module rgb_word_pack
    import rgb_pkg::*;
#(
    parameter int BITS_PER_LED = 24
) (
    input  wire logic       clk,
    input  wire logic       rst,
    rgb_word_pack_if.slave  bus
);

    if (BITS_PER_LED != LED_BITS) begin : g_bad_width
        $error("rgb_word_pack: only BITS_PER_LED = 24 is supported");
    end

    logic        evt;

    logic [23:0] shreg_q,        shreg_d;
    logic [4:0]  bit_cnt_q,      bit_cnt_d;
    logic        last_was_rst_q, last_was_rst_d;
    pack_state_e state_q,        state_d;
    logic        wr_en_q,        wr_en_d;
    logic [31:0] wr_data_q,      wr_data_d;
    logic        overflow_q,     overflow_d;
    logic        frame_err_q,    frame_err_d;

    logic        new_word_vld;
    logic [31:0] new_word;

    rgb_strobe_rise u_strobe_rise (
        .clk      (clk),
        .rst      (rst),
        .i_strobe (bus.in_strobe),
        .o_event  (evt)
    );

    always_comb begin
        shreg_d        = shreg_q;
        bit_cnt_d      = bit_cnt_q;
        last_was_rst_d = last_was_rst_q;
        state_d        = state_q;
        wr_en_d        = 1'b0;
        wr_data_d      = wr_data_q;
        overflow_d     = overflow_q;
        frame_err_d    = frame_err_q;
        new_word_vld   = 1'b0;
        new_word       = '0;

        if (evt) begin
            if (bus.in_stream_reset) begin
                if (bit_cnt_q != 5'd0) begin
                    shreg_d     = '0;
                    bit_cnt_d   = 5'd0;
                    frame_err_d = 1'b1;
                end
                // Back-to-back line resets collapse into a single marker word.
                if (!last_was_rst_q) begin
                    new_word_vld   = 1'b1;
                    new_word       = STREAM_RESET_WORD;
                    last_was_rst_d = 1'b1;
                end
            end else begin
                shreg_d = {shreg_q[22:0], bus.in_sbit_value};
                if (bit_cnt_q == 5'(LED_BITS - 1)) begin
                    new_word_vld   = 1'b1;
                    new_word       = make_data_word(shreg_d);
                    bit_cnt_d      = 5'd0;
                    last_was_rst_d = 1'b0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 5'd1;
                end
            end
        end

        case (state_q)
            S_IDLE: begin
                if (new_word_vld) begin
                    wr_data_d = new_word;
                    state_d   = S_PEND;
                end
            end
            S_PEND: begin
                if (!bus.in_wr_fifo_full) begin
                    wr_en_d = 1'b1;
                    state_d = S_IDLE;
                end
                // Only one slot: a word arriving while one waits is lost.
                if (new_word_vld) begin
                    overflow_d = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q        <= '0;
            bit_cnt_q      <= 5'd0;
            last_was_rst_q <= 1'b0;
            state_q        <= S_IDLE;
            wr_en_q        <= 1'b0;
            wr_data_q      <= '0;
            overflow_q     <= 1'b0;
            frame_err_q    <= 1'b0;
        end else begin
            shreg_q        <= shreg_d;
            bit_cnt_q      <= bit_cnt_d;
            last_was_rst_q <= last_was_rst_d;
            state_q        <= state_d;
            wr_en_q        <= wr_en_d;
            wr_data_q      <= wr_data_d;
            overflow_q     <= overflow_d;
            frame_err_q    <= frame_err_d;
        end
    end

    assign bus.out_wr_fifo_en   = wr_en_q;
    assign bus.out_wr_fifo_data = wr_data_q;
    assign bus.out_overflow     = overflow_q;
    assign bus.out_frame_err    = frame_err_q;

`ifdef RGB_WORD_PACK_STATS_EN
    logic [15:0] led_count_q, led_count_d;

    always_comb begin
        led_count_d = led_count_q;
        if (wr_en_d) begin
            if (wr_data_q[BNUM_STREAM_RESET]) begin
                led_count_d = 16'd0;
            end else if (led_count_q != 16'hFFFF) begin
                led_count_d = led_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            led_count_q <= 16'd0;
        end else begin
            led_count_q <= led_count_d;
        end
    end

    assign bus.out_led_count = led_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rgb_word_pack.sv
`default_nettype none
// ============================================================================
// Module   : tb_rgb_word_pack
// Purpose  : Directed self-checking bench for rgb_word_pack.
// Revision : 1.0
// ============================================================================
module tb_rgb_word_pack;

    localparam int GAP = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_total = 0;
    int n_pass  = 0;

    logic [31:0] wr_q[$];
    logic        en_prev = 1'b0;

    rgb_word_pack_if bus ();

    rgb_word_pack #(.BITS_PER_LED(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Capture every FIFO write away from the active edge.
    always @(negedge clk) begin
        if (bus.out_wr_fifo_en === 1'b1) begin
            wr_q.push_back(bus.out_wr_fifo_data);
            if (en_prev) chk("en_back_to_back", 32'd1, 32'd0);
        end
        en_prev = (bus.out_wr_fifo_en === 1'b1);
    end

    task automatic send_ev(input logic sr, input logic v, input int hold);
        bus.in_strobe       = 1'b1;
        bus.in_stream_reset = sr;
        bus.in_sbit_value   = v;
        repeat (hold) @(negedge clk);
        bus.in_strobe       = 1'b0;
        bus.in_stream_reset = 1'b0;
        bus.in_sbit_value   = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic send_word(input logic [23:0] w, input int hold);
        for (int i = 23; i >= 0; i--) send_ev(1'b0, w[i], hold);
    endtask

    initial begin
        logic [23:0] pix;
        bus.in_strobe       = 1'b0;
        bus.in_stream_reset = 1'b0;
        bus.in_sbit_value   = 1'b0;
        bus.in_wr_fifo_full = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_en",    32'(bus.out_wr_fifo_en), 32'd0);
        chk("rst_data",  bus.out_wr_fifo_data,    32'd0);
        chk("rst_ovf",   32'(bus.out_overflow),   32'd0);
        chk("rst_ferr",  32'(bus.out_frame_err),  32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Pixel 0x123456 with write latency checked on the completing bit.
        wr_q.delete();
        pix = 24'h123456;
        for (int i = 23; i >= 1; i--) send_ev(1'b0, pix[i], 2);
        bus.in_strobe     = 1'b1;
        bus.in_sbit_value = pix[0];
        @(posedge clk); #1;
        chk("lat_e0_en", 32'(bus.out_wr_fifo_en), 32'd0);
        @(posedge clk); #1;
        chk("lat_e1_en",   32'(bus.out_wr_fifo_en), 32'd1);
        chk("lat_e1_data", bus.out_wr_fifo_data,    32'h8012_3456);
        @(negedge clk);
        bus.in_strobe     = 1'b0;
        bus.in_sbit_value = 1'b0;
        @(posedge clk); #1;
        chk("lat_e2_en",   32'(bus.out_wr_fifo_en), 32'd0);
        chk("hold_data",   bus.out_wr_fifo_data,    32'h8012_3456);
        repeat (GAP) @(negedge clk);
        send_ev(1'b1, 1'b0, 2);
        repeat (4) @(negedge clk);
        chk("t1_count", 32'(wr_q.size()), 32'd2);
        chk("t1_w0",    wr_q[0],          32'h8012_3456);
        chk("t1_w1",    wr_q[1],          32'hC000_0000);

        // Two-cycle versus five-cycle strobes.
        wr_q.delete();
        send_word(24'hA5F00F, 2);
        send_word(24'h0F1E2D, 5);
        repeat (4) @(negedge clk);
        chk("t2_count", 32'(wr_q.size()), 32'd2);
        chk("t2_w0",    wr_q[0],          32'h80A5_F00F);
        chk("t2_w1",    wr_q[1],          32'h800F_1E2D);

        // FIFO full when the word completes, released 50 cycles later.
        wr_q.delete();
        bus.in_wr_fifo_full = 1'b1;
        send_word(24'h654321, 2);
        repeat (50) @(negedge clk);
        chk("t3_no_write", 32'(wr_q.size()),       32'd0);
        chk("t3_held",     bus.out_wr_fifo_data,   32'h8065_4321);
        chk("t3_ovf_clr",  32'(bus.out_overflow),  32'd0);
        bus.in_wr_fifo_full = 1'b0;
        @(posedge clk); #1;
        chk("t3_en",   32'(bus.out_wr_fifo_en), 32'd1);
        chk("t3_data", bus.out_wr_fifo_data,    32'h8065_4321);
        repeat (3) @(negedge clk);
        chk("t3_count", 32'(wr_q.size()), 32'd1);

        // Two pixels complete while full: second is dropped.
        wr_q.delete();
        bus.in_wr_fifo_full = 1'b1;
        send_word(24'h111111, 2);
        send_word(24'h222222, 2);
        repeat (5) @(negedge clk);
        chk("t4_ovf",      32'(bus.out_overflow), 32'd1);
        chk("t4_no_write", 32'(wr_q.size()),      32'd0);
        bus.in_wr_fifo_full = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_count", 32'(wr_q.size()), 32'd1);
        chk("t4_w0",    wr_q[0],          32'h8011_1111);

        // Partial pixel, then two stream resets.
        wr_q.delete();
        chk("t5_ferr_pre", 32'(bus.out_frame_err), 32'd0);
        for (int i = 0; i < 10; i++) send_ev(1'b0, 1'(i & 1), 2);
        send_ev(1'b1, 1'b0, 2);
        send_ev(1'b1, 1'b0, 2);
        repeat (4) @(negedge clk);
        chk("t5_ferr",  32'(bus.out_frame_err), 32'd1);
        chk("t5_count", 32'(wr_q.size()),       32'd1);
        chk("t5_w0",    wr_q[0],                32'hC000_0000);

        // Reset in the middle of a pixel.
        wr_q.delete();
        for (int i = 0; i < 12; i++) send_ev(1'b0, 1'b1, 2);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("t6_en",   32'(bus.out_wr_fifo_en), 32'd0);
        chk("t6_data", bus.out_wr_fifo_data,    32'd0);
        chk("t6_ovf",  32'(bus.out_overflow),   32'd0);
        chk("t6_ferr", 32'(bus.out_frame_err),  32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        send_word(24'hFFFFFF, 2);
        repeat (4) @(negedge clk);
        chk("t6_count", 32'(wr_q.size()), 32'd1);
        chk("t6_w0",    wr_q[0],          32'h80FF_FFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
